// File: rtl/im_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
// The loader owns the master modport; the stream source and IM sit on the slave side.
interface im_loader_if;
  logic [7:0]  rx_data;
  logic        rx_vld;
  logic        im_we;
  logic [15:0] im_waddr;
  logic [16:0] im_wdata;

  modport master (
    input  rx_data, rx_vld,
    output im_we, im_waddr, im_wdata
  );

  modport slave (
    output rx_data, rx_vld,
    input  im_we, im_waddr, im_wdata
  );
endinterface

// File: rtl/im_loader.sv
// Program loader: parses a length header plus packed 17-bit words and fills IM from address 0.
// Define IM_LOADER_CHKSUM_EN to require a trailing XOR checksum byte after the payload.
module im_loader #(
  parameter int DEPTH   = 2048,
  parameter int TIMEOUT = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  im_loader_if.master bus,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code,
  output logic [11:0] words_loaded
);

  typedef enum logic [3:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_B0, S_B1, S_B2, S_DONE, S_ERR
`ifdef IM_LOADER_CHKSUM_EN
    , S_CHK
`endif
  } state_e;

  localparam logic [1:0]  ERR_LEN   = 2'b01;
  localparam logic [1:0]  ERR_TMO   = 2'b10;
  localparam logic [1:0]  ERR_CHK   = 2'b11;
  localparam logic [15:0] DEPTH_L   = 16'(DEPTH);
  localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic        busy_q, busy_d;
  logic        hold_q, hold_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [1:0]  code_q, code_d;
  logic        we_q, we_d;
  logic [15:0] waddr_q, waddr_d;
  logic [16:0] wdata_q, wdata_d;
  logic [15:0] addr_q, addr_d;
  logic [11:0] wl_q, wl_d;
  logic [15:0] len_q, len_d;
  logic        b0_q, b0_d;
  logic [7:0]  b1_q, b1_d;
  logic [15:0] tmo_q, tmo_d;
  logic [15:0] len_rx;
`ifdef IM_LOADER_CHKSUM_EN
  logic [7:0]  chk_q, chk_d;
`endif

  assign len_rx = {len_q[15:8], bus.rx_data};

  always_comb begin
    // NOTE: every _d gets its hold value first so no path through the case leaves a latch.
    state_d = state_q;
    busy_d  = busy_q;
    hold_d  = hold_q;
    done_d  = done_q;
    err_d   = err_q;
    code_d  = code_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    addr_d  = addr_q;
    wl_d    = wl_q;
    len_d   = len_q;
    b0_d    = b0_q;
    b1_d    = b1_q;
    tmo_d   = tmo_q;
`ifdef IM_LOADER_CHKSUM_EN
    chk_d   = chk_q;
`endif

    if (busy_q) tmo_d = bus.rx_vld ? 16'd0 : tmo_q + 16'd1;

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d = S_LEN_HI;
          busy_d  = 1'b1;
          hold_d  = 1'b1;
          done_d  = 1'b0;
          err_d   = 1'b0;
          code_d  = 2'b00;
          addr_d  = 16'd0;
          wl_d    = 12'd0;
          tmo_d   = 16'd0;
`ifdef IM_LOADER_CHKSUM_EN
          chk_d   = 8'd0;
`endif
        end
      end
      S_LEN_HI: if (bus.rx_vld) begin
        len_d[15:8] = bus.rx_data;
        state_d     = S_LEN_LO;
      end
      S_LEN_LO: if (bus.rx_vld) begin
        len_d = len_rx;
        if (len_rx == 16'd0 || len_rx > DEPTH_L) begin
          state_d = S_ERR;
          busy_d  = 1'b0;
          err_d   = 1'b1;
          code_d  = ERR_LEN;
        end else begin
          state_d = S_B0;
        end
      end
      S_B0: if (bus.rx_vld) begin
        b0_d    = bus.rx_data[0];
        state_d = S_B1;
`ifdef IM_LOADER_CHKSUM_EN
        chk_d   = chk_q ^ bus.rx_data;
`endif
      end
      S_B1: if (bus.rx_vld) begin
        b1_d    = bus.rx_data;
        state_d = S_B2;
`ifdef IM_LOADER_CHKSUM_EN
        chk_d   = chk_q ^ bus.rx_data;
`endif
      end
      S_B2: if (bus.rx_vld) begin
        we_d    = 1'b1;
        waddr_d = addr_q;
        wdata_d = {b0_q, b1_q, bus.rx_data};
        addr_d  = addr_q + 16'd1;
        wl_d    = wl_q + 12'd1;
`ifdef IM_LOADER_CHKSUM_EN
        chk_d   = chk_q ^ bus.rx_data;
`endif
        if (addr_q + 16'd1 == len_q) begin
`ifdef IM_LOADER_CHKSUM_EN
          state_d = S_CHK;
`else
          state_d = S_DONE;
          busy_d  = 1'b0;
          hold_d  = 1'b0;
          done_d  = 1'b1;
`endif
        end else begin
          state_d = S_B0;
        end
      end
`ifdef IM_LOADER_CHKSUM_EN
      S_CHK: if (bus.rx_vld) begin
        busy_d = 1'b0;
        if (bus.rx_data == chk_q) begin
          state_d = S_DONE;
          hold_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d = S_ERR;
          err_d   = 1'b1;
          code_d  = ERR_CHK;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

    // Idle gap check: only reachable while no byte arrives, so no byte transition is overridden.
    if (busy_q && !bus.rx_vld && tmo_q == TMO_LAST) begin
      state_d = S_ERR;
      busy_d  = 1'b0;
      err_d   = 1'b1;
      code_d  = ERR_TMO;
    end
  end

  // NOTE: non-blocking assignments so every flop samples its peers' pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      hold_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= 2'b00;
      we_q    <= 1'b0;
      waddr_q <= 16'd0;
      wdata_q <= 17'd0;
      addr_q  <= 16'd0;
      wl_q    <= 12'd0;
      len_q   <= 16'd0;
      b0_q    <= 1'b0;
      b1_q    <= 8'd0;
      tmo_q   <= 16'd0;
`ifdef IM_LOADER_CHKSUM_EN
      chk_q   <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      err_q   <= err_d;
      code_q  <= code_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      addr_q  <= addr_d;
      wl_q    <= wl_d;
      len_q   <= len_d;
      b0_q    <= b0_d;
      b1_q    <= b1_d;
      tmo_q   <= tmo_d;
`ifdef IM_LOADER_CHKSUM_EN
      chk_q   <= chk_d;
`endif
    end
  end

  assign bus.im_we    = we_q;
  assign bus.im_waddr = waddr_q;
  assign bus.im_wdata = wdata_q;
  assign cpu_hold     = hold_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;
  assign err_code     = code_q;
  assign words_loaded = wl_q;

endmodule

// File: tb/tb_im_loader.sv
// Directed self-checking bench for im_loader (TIMEOUT shortened to 20 cycles).
// Honours IM_LOADER_CHKSUM_EN the same way the design does.
module tb_im_loader;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        cpu_hold, busy, done, err;
  logic [1:0]  err_code;
  logic [11:0] words_loaded;

  int tests = 0;
  int fails = 0;

  im_loader_if bus ();

  im_loader #(.DEPTH(2048), .TIMEOUT(20)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .bus          (bus),
    .cpu_hold     (cpu_hold),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .err_code     (err_code),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  // IM model: captures a write on the rising edge that ends the im_we cycle.
  logic [16:0] mem [0:2047];
  int          we_cnt = 0;
  logic [15:0] last_addr = '0;
  logic [16:0] last_data = '0;
  always @(posedge clk) begin
    if (bus.im_we) begin
      mem[bus.im_waddr[10:0]] <= bus.im_wdata;
      we_cnt    <= we_cnt + 1;
      last_addr <= bus.im_waddr;
      last_data <= bus.im_wdata;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    bus.rx_data = b;
    bus.rx_vld  = 1'b1;
    tick();
  endtask

  task automatic pulse_start();
    bus.rx_vld = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic check_reset_values(input string pfx);
    check({pfx, "_we"},    bus.im_we, 0);
    check({pfx, "_waddr"}, bus.im_waddr, 0);
    check({pfx, "_wdata"}, bus.im_wdata, 0);
    check({pfx, "_hold"},  cpu_hold, 0);
    check({pfx, "_busy"},  busy, 0);
    check({pfx, "_done"},  done, 0);
    check({pfx, "_err"},   err, 0);
    check({pfx, "_code"},  err_code, 0);
    check({pfx, "_wl"},    words_loaded, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    logic [16:0] exp_w;
    bus.rx_data = 8'h00;
    bus.rx_vld  = 1'b0;

    #12;
    check_reset_values("rst");
    rst_n = 1'b1;
    tick();

    // Two-word load, bytes one per cycle with no gaps.
    pulse_start();
    check("start_busy", busy, 1);
    check("start_hold", cpu_hold, 1);
    n0 = we_cnt;
    send(8'h00); send(8'h02); send(8'h01); send(8'hAB); send(8'hCD);
    check("w0_we", bus.im_we, 1);
    check("w0_addr", bus.im_waddr, 16'h0000);
    check("w0_data", bus.im_wdata, 17'h1ABCD);
    send(8'h00);
    check("w0_we_one_cycle", bus.im_we, 0);
    send(8'h12); send(8'h34);
    check("w1_we", bus.im_we, 1);
    check("w1_addr", bus.im_waddr, 16'h0001);
    check("w1_data", bus.im_wdata, 17'h01234);
`ifdef IM_LOADER_CHKSUM_EN
    check("w1_not_done_yet", done, 0);
    send(8'h41);
`endif
    bus.rx_vld = 1'b0;
    check("load2_done", done, 1);
    check("load2_busy", busy, 0);
    check("load2_hold", cpu_hold, 0);
    check("load2_err", err, 0);
    check("load2_wl", words_loaded, 2);
    tick();
    check("load2_we_cnt", we_cnt - n0, 2);
    check("load2_mem0", mem[0], 17'h1ABCD);
    check("load2_mem1", mem[1], 17'h01234);

`ifdef IM_LOADER_CHKSUM_EN
    // Same payload with a wrong trailer.
    pulse_start();
    check("chk_done_cleared", done, 0);
    send(8'h00); send(8'h02); send(8'h01); send(8'hAB); send(8'hCD);
    send(8'h00); send(8'h12); send(8'h34); send(8'h42);
    bus.rx_vld = 1'b0;
    check("chkbad_err", err, 1);
    check("chkbad_code", err_code, 2'b11);
    check("chkbad_hold", cpu_hold, 1);
    check("chkbad_done", done, 0);
    tick();
`endif

    // Zero-length header.
    pulse_start();
    n0 = we_cnt;
    send(8'h00); send(8'h00);
    bus.rx_vld = 1'b0;
    check("len0_err", err, 1);
    check("len0_code", err_code, 2'b01);
    check("len0_busy", busy, 0);
    check("len0_hold", cpu_hold, 1);
    tick();
    check("len0_no_we", we_cnt - n0, 0);

    // Length one past DEPTH.
    pulse_start();
    check("len2049_err_cleared", err, 0);
    check("len2049_code_cleared", err_code, 0);
    send(8'h08); send(8'h01);
    bus.rx_vld = 1'b0;
    check("len2049_err", err, 1);
    check("len2049_code", err_code, 2'b01);
    tick();
    check("len2049_no_we", we_cnt - n0, 0);

    // Idle timeout: error exactly TIMEOUT cycles after the last accepted byte.
    pulse_start();
    send(8'h00); send(8'h01); send(8'hAA);
    bus.rx_vld = 1'b0;
    for (int i = 0; i < 19; i++) tick();
    check("tmo_not_yet", err, 0);
    check("tmo_still_busy", busy, 1);
    tick();
    check("tmo_err", err, 1);
    check("tmo_code", err_code, 2'b10);
    check("tmo_busy", busy, 0);
    check("tmo_hold", cpu_hold, 1);

    // Fresh reset, then bytes in IDLE are dropped and start while busy is ignored.
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
    send(8'h12); send(8'h34);
    bus.rx_vld = 1'b0;
    tick();
    check("idle_bytes_busy", busy, 0);
    pulse_start();
    send(8'h00); send(8'h01);
    pulse_start();
    check("start_ignored_busy", busy, 1);
    send(8'h00); send(8'h00); send(8'h07);
    check("idle_we", bus.im_we, 1);
    check("idle_addr", bus.im_waddr, 16'h0000);
    check("idle_data", bus.im_wdata, 17'h00007);
`ifdef IM_LOADER_CHKSUM_EN
    send(8'h07);
`endif
    bus.rx_vld = 1'b0;
    check("idle_done", done, 1);
    check("idle_wl", words_loaded, 1);
    tick();

    // Full-depth header, 100 words back-to-back, then reset mid-load.
    pulse_start();
    n0 = we_cnt;
    send(8'h08); send(8'h00);
    check("len2048_accepted", err, 0);
    for (int i = 0; i < 100; i++) begin
      send(8'hFE | 8'(i & 1));
      send(8'(i) ^ 8'h5A);
      send(8'(i));
    end
    check("long_wl", words_loaded, 100);
    send(8'h01);
    bus.rx_vld = 1'b0;
    check("long_we_cnt", we_cnt - n0, 100);
    for (int i = 0; i < 100; i += 33) begin
      exp_w = {1'(i & 1), 8'(i) ^ 8'h5A, 8'(i)};
      check($sformatf("long_mem%0d", i), mem[i], exp_w);
    end
    check("long_mem99", mem[99], {1'b1, 8'd99 ^ 8'h5A, 8'd99});
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("async");
    #3;
    rst_n = 1'b1;
    tick();

    // Reload after reset starts again from address 0.
    pulse_start();
    send(8'h00); send(8'h01); send(8'h01); send(8'h23); send(8'h45);
`ifdef IM_LOADER_CHKSUM_EN
    send(8'h01 ^ 8'h23 ^ 8'h45);
`endif
    bus.rx_vld = 1'b0;
    tick();
    check("reload_addr", last_addr, 16'h0000);
    check("reload_data", last_data, 17'h12345);
    check("reload_done", done, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
